// File: rtl/addsub_exhaustive_checker.sv
// ============================================================================
// Module   : addsub_exhaustive_checker
// Brief    : Drives every {S,A,B} vector into an external adder/subtractor,
//            waits SETTLE cycles, and tallies pass/fail against the
//            two's-complement reference. Optional macro
//            ADDSUB_CHK_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_exhaustive_checker #(
    parameter int WIDTH  = 6,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     B,
    output logic                 S,
    input  logic [WIDTH-1:0]     ANSWER,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH+1:0]   pass_count,
    output logic [2*WIDTH+1:0]   fail_count,
    output logic [2*WIDTH:0]     first_fail
);

    localparam int c_idx_w = 2*WIDTH + 1;
    localparam int c_cnt_w = 2*WIDTH + 2;

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_drive = 3'd1;
    localparam logic [2:0] c_wait  = 3'd2;
    localparam logic [2:0] c_check = 3'd3;
    localparam logic [2:0] c_done  = 3'd4;

    localparam logic [3:0]         c_settle_m1 = 4'(SETTLE - 1);
    localparam logic [c_idx_w-1:0] c_idx_one   = {{(c_idx_w-1){1'b0}}, 1'b1};
    localparam logic [c_cnt_w-1:0] c_cnt_one   = {{(c_cnt_w-1){1'b0}}, 1'b1};

    logic [2:0]          r_state;
    logic [c_idx_w-1:0]  r_idx;
    logic [3:0]          r_wait;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic                r_s;
    logic                r_busy;
    logic                r_done;
    logic [c_cnt_w-1:0]  r_pass;
    logic [c_cnt_w-1:0]  r_fail;
    logic [c_idx_w-1:0]  r_first;

    logic [WIDTH-1:0]    w_expected;
    logic                w_match;
    logic                w_last;
    logic                w_stop;

    // Carry/borrow out is dropped by truncation to WIDTH bits.
    assign w_expected = r_s ? (r_a - r_b) : (r_a + r_b);
    assign w_match    = (ANSWER == w_expected);
    assign w_last     = &r_idx;

`ifdef ADDSUB_CHK_STOP_ON_FAIL_EN
    assign w_stop = w_last | ~w_match;
`else
    assign w_stop = w_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_idx   <= '0;
            r_wait  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= '0;
            r_fail  <= '0;
            r_first <= '0;
        end else begin
            case (r_state)
                c_idle, c_done: begin
                    if (start) begin
                        r_state <= c_drive;
                        r_idx   <= '0;
                        r_pass  <= '0;
                        r_fail  <= '0;
                        r_first <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                c_drive: begin
                    r_s     <= r_idx[2*WIDTH];
                    r_a     <= r_idx[2*WIDTH-1:WIDTH];
                    r_b     <= r_idx[WIDTH-1:0];
                    r_wait  <= c_settle_m1;
                    r_state <= c_wait;
                end
                c_wait: begin
                    if (r_wait == 4'd0) begin
                        r_state <= c_check;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                c_check: begin
                    if (w_match) begin
                        r_pass <= r_pass + c_cnt_one;
                    end else begin
                        r_fail <= r_fail + c_cnt_one;
                        if (r_fail == '0) begin
                            r_first <= r_idx;
                        end
                    end
                    if (w_stop) begin
                        r_state <= c_done;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + c_idx_one;
                        r_state <= c_drive;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign A          = r_a;
    assign B          = r_b;
    assign S          = r_s;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass_count = r_pass;
    assign fail_count = r_fail;
    assign first_fail = r_first;

endmodule

`default_nettype wire

// File: tb/tb_addsub_exhaustive_checker.sv
// ============================================================================
// Module   : tb_addsub_exhaustive_checker
// Brief    : Self-checking bench: full WIDTH=6 sweep, stuck-at-0 WIDTH=2 unit,
//            and randomly faulted WIDTH=3 unit with a counting reference.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_addsub_exhaustive_checker;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic start6 = 1'b0;
    logic start2 = 1'b0;
    logic start3 = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    localparam int N6 = 8192;
    localparam int T6 = 3 * N6;

    // Unit-under-test behaviour: plain modular arithmetic on the decoded vector.
    function automatic int addsub_ref(input int w, input int idx);
        int m, a, b, s;
        m = 1 << w;
        s = (idx >> (2*w)) & 1;
        a = (idx >> w) & (m - 1);
        b = idx & (m - 1);
        return (s != 0) ? ((((a - b) % m) + m) % m) : ((a + b) % m);
    endfunction

    logic [5:0]  a6, b6, ans6;
    logic        s6, busy6, done6;
    logic [13:0] pass6, fail6;
    logic [12:0] ff6;
    assign ans6 = 6'(addsub_ref(6, int'({s6, a6, b6})));

    logic [1:0]  a2, b2;
    logic        s2, busy2, done2;
    logic [5:0]  pass2, fail2;
    logic [4:0]  ff2;

    logic [2:0]   a3, b3, ans3;
    logic         s3, busy3, done3;
    logic [7:0]   pass3, fail3;
    logic [6:0]   ff3;
    logic [127:0] bad3 = '0;
    assign ans3 = 3'(addsub_ref(3, int'({s3, a3, b3}))) ^ {2'b00, bad3[{s3, a3, b3}]};

    addsub_exhaustive_checker #(.WIDTH(6), .SETTLE(1)) u_dut6 (
        .clk(clk), .rst(rst), .start(start6), .A(a6), .B(b6), .S(s6),
        .ANSWER(ans6), .busy(busy6), .done(done6), .pass_count(pass6),
        .fail_count(fail6), .first_fail(ff6)
    );

    addsub_exhaustive_checker #(.WIDTH(2), .SETTLE(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2), .S(s2),
        .ANSWER(2'b00), .busy(busy2), .done(done2), .pass_count(pass2),
        .fail_count(fail2), .first_fail(ff2)
    );

    addsub_exhaustive_checker #(.WIDTH(3), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .A(a3), .B(b3), .S(s3),
        .ANSWER(ans3), .busy(busy3), .done(done3), .pass_count(pass3),
        .fail_count(fail3), .first_fail(ff3)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic kick(input int which);
        @(negedge clk);
        if (which == 6) start6 = 1'b1;
        else if (which == 2) start2 = 1'b1;
        else start3 = 1'b1;
        @(posedge clk);
        #1;
        start6 = 1'b0;
        start2 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int limit, output int cyc);
        logic d;
        cyc = 0;
        d = (which == 6) ? done6 : (which == 2) ? done2 : done3;
        while (!d && cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
            d = (which == 6) ? done6 : (which == 2) ? done2 : done3;
        end
    endtask

    typedef struct {
        int off;
        int a;
        int b;
        int s;
        int busy;
        int done;
        int pass;
        int fail;
    } chk_t;

    // Expected WIDTH=6 outputs 'off' cycles after the start edge.
    function automatic chk_t expect6(input int off);
        chk_t c;
        int k;
        c.off  = off;
        k      = (off == 0) ? 0 : (off - 1) / 3;
        if (k > N6 - 1) k = N6 - 1;
        c.s    = (k >> 12) & 1;
        c.a    = (k >> 6) & 63;
        c.b    = k & 63;
        c.busy = (off < T6) ? 1 : 0;
        c.done = (off >= T6) ? 1 : 0;
        c.pass = (off >= T6) ? N6 : off / 3;
        c.fail = 0;
        return c;
    endfunction

    chk_t tbl [15];
    int   offs [15] = '{0, 1, 2, 3, 4, 7, 100, 20950, 20951, 20952,
                        24574, 24575, 24576, 24577, 24600};

    initial begin
        int cur, cyc, rnd;
        int exp_cyc, exp_pass, exp_fail, exp_ff;

        for (int i = 0; i < 15; i++) tbl[i] = expect6(offs[i]);

        repeat (2) @(posedge clk);
        #1;
        check("rst_a6", a6, 0);
        check("rst_b6", b6, 0);
        check("rst_s6", s6, 0);
        check("rst_busy6", busy6, 0);
        check("rst_done6", done6, 0);
        check("rst_pass6", pass6, 0);
        check("rst_fail6", fail6, 0);
        check("rst_ff6", ff6, 0);
        check("rst_busy2", busy2, 0);
        check("rst_busy3", busy3, 0);
        @(negedge clk);
        rst = 1'b0;

        // Full correct sweep, checkpoints from the table.
        kick(6);
        cur = 0;
        for (int i = 0; i < 15; i++) begin
            while (cur < tbl[i].off) begin
                @(posedge clk);
                #1;
                cur++;
            end
            check($sformatf("t%0d_a", tbl[i].off), a6, tbl[i].a);
            check($sformatf("t%0d_b", tbl[i].off), b6, tbl[i].b);
            check($sformatf("t%0d_s", tbl[i].off), s6, tbl[i].s);
            check($sformatf("t%0d_busy", tbl[i].off), busy6, tbl[i].busy);
            check($sformatf("t%0d_done", tbl[i].off), done6, tbl[i].done);
            check($sformatf("t%0d_pass", tbl[i].off), pass6, tbl[i].pass);
            check($sformatf("t%0d_fail", tbl[i].off), fail6, tbl[i].fail);
        end
        check("sweep_ff6", ff6, 0);

        // Index 6983 decodes to 45 - 7 = 38; verify at its CHECK boundary.
        kick(6);
        cur = 0;
        while (cur < 3 * 6983 + 2) begin
            @(posedge clk);
            #1;
            cur++;
        end
        check("v6983_a", a6, 45);
        check("v6983_b", b6, 7);
        check("v6983_s", s6, 1);
        check("v6983_ans", ans6, 38);
        @(posedge clk);
        #1;
        check("v6983_pass", pass6, 6984);
        check("v6983_fail", fail6, 0);

        // Start while busy is ignored.
        start6 = 1'b1;
        @(posedge clk);
        #1;
        start6 = 1'b0;
        cur = 3 * 6983 + 4;
        check("busy_start_pass", pass6, cur / 3);
        check("busy_start_busy", busy6, 1);
        check("busy_start_b", b6, ((cur - 1) / 3) & 63);

        // Reset together with start: reset wins, results cleared.
        rst    = 1'b1;
        start6 = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        start6 = 1'b0;
        check("abort_busy", busy6, 0);
        check("abort_done", done6, 0);
        check("abort_pass", pass6, 0);
        check("abort_fail", fail6, 0);
        check("abort_ff", ff6, 0);
        check("abort_a", a6, 0);
        check("abort_s", s6, 0);
        @(posedge clk);
        #1;
        check("abort_idle", busy6, 0);
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #1;

        // Fresh sweep with a random stray start pulse mid-run.
        kick(6);
        rnd = $urandom_range(10, 20000);
        cyc = 0;
        while (!done6 && cyc < T6 + 50) begin
            start6 = (cyc == rnd);
            @(posedge clk);
            #1;
            cyc++;
        end
        start6 = 1'b0;
        check("restart_cycles", cyc, T6);
        check("restart_pass", pass6, N6);
        check("restart_fail", fail6, 0);
        check("restart_busy", busy6, 0);

        // Stuck-at-zero WIDTH=2 unit.
        kick(2);
        wait_done(2, 200, cyc);
`ifdef ADDSUB_CHK_STOP_ON_FAIL_EN
        check("stuck_cycles", cyc, 6);
        check("stuck_pass", pass2, 1);
        check("stuck_fail", fail2, 1);
`else
        check("stuck_cycles", cyc, 96);
        check("stuck_pass", pass2, 8);
        check("stuck_fail", fail2, 24);
`endif
        check("stuck_ff", ff2, 1);
        check("stuck_busy", busy2, 0);

        // Randomly faulted WIDTH=3 unit against a counting reference.
        for (int r = 0; r < 4; r++) begin
            int a, b, s, want, got;
            for (int i = 0; i < 128; i++) bad3[i] = (r != 0) && ($urandom_range(0, 7) == 0);
            exp_pass = 0;
            exp_fail = 0;
            exp_ff   = 0;
            for (int i = 0; i < 128; i++) begin
                s    = i >> 6;
                a    = (i >> 3) & 7;
                b    = i & 7;
                want = ((s != 0) ? (a - b) : (a + b)) & 7;
                got  = addsub_ref(3, i) ^ int'(bad3[i]);
                if (got == want) begin
                    exp_pass++;
                end else begin
                    if (exp_fail == 0) exp_ff = i;
                    exp_fail++;
`ifdef ADDSUB_CHK_STOP_ON_FAIL_EN
                    break;
`endif
                end
            end
            exp_cyc = (exp_pass + exp_fail) * 5;
            kick(3);
            check($sformatf("r%0d_clr_pass", r), pass3, 0);
            check($sformatf("r%0d_clr_fail", r), fail3, 0);
            check($sformatf("r%0d_clr_done", r), done3, 0);
            check($sformatf("r%0d_clr_busy", r), busy3, 1);
            wait_done(3, 800, cyc);
            check($sformatf("r%0d_cycles", r), cyc, exp_cyc);
            check($sformatf("r%0d_pass", r), pass3, exp_pass);
            check($sformatf("r%0d_fail", r), fail3, exp_fail);
            check($sformatf("r%0d_ff", r), ff3, exp_ff);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("r%0d_hold_done", r), done3, 1);
            check($sformatf("r%0d_hold_pass", r), pass3, exp_pass);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
